gray_counter_n: RTL



---
 rtl/gray_counter_n.sv | 93 +++++++++
 1 files changed

// File: rtl/gray_counter_n.sv
// gray_counter_n: WIDTH-bit up/down counter with registered binary and Gray
// outputs, sync clear, parallel load, and overflow/underflow wrap flags.
// Ports: Clk, Reset_n (async, active-low), Clr, En, Dir (1=up), Load,
//   LoadVal[WIDTH] in; Gray[WIDTH], Bin[WIDTH], Overflow, Underflow out.
// Macro GRAY_STICKY_FLAG_EN: flags hold until Clr/reset; else 1-cycle pulses.
module gray_counter_n #(
  parameter int WIDTH = 3
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Clr,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  output logic [WIDTH-1:0] Gray,
  output logic [WIDTH-1:0] Bin,
  output logic             Overflow,
  output logic             Underflow
);

  localparam logic [WIDTH-1:0] ONE =
    {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  // Mutually exclusive qualifiers encode the
  // Clr > Load > step priority.
  logic do_clr, do_load, do_up, do_dn;

  assign do_clr  = Clr;
  assign do_load = ~Clr & Load;
  assign do_up   = ~Clr & ~Load & En & Dir;
  assign do_dn   = ~Clr & ~Load & En & ~Dir;

  always_comb begin
    cnt_d = cnt_q;
`ifdef GRAY_STICKY_FLAG_EN
    ovf_d = ovf_q;
    unf_d = unf_q;
`else
    ovf_d = 1'b0;
    unf_d = 1'b0;
`endif
    unique case (1'b1)
      do_clr: begin
        cnt_d = ZERO;
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      do_load: begin
        cnt_d = LoadVal;
      end
      do_up: begin
        cnt_d = cnt_q + ONE;
        if (cnt_q == MAX) ovf_d = 1'b1;
      end
      do_dn: begin
        cnt_d = cnt_q - ONE;
        if (cnt_q == ZERO) unf_d = 1'b1;
      end
      default: ;
    endcase
    // Gray is encoded from the next value so the
    // output is a plain register with no decode.
    gray_d = cnt_d ^ (cnt_d >> 1);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q  <= ZERO;
      gray_q <= ZERO;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      gray_q <= gray_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign Bin       = cnt_q;
  assign Gray      = gray_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

endmodule
